// File: rtl/cam_frame_capture_if.sv
// Signal bundle between the camera/control side and the capture engine.
// CAM_CAPTURE_DECIMATE_EN adds the decim control line.
interface cam_frame_capture_if #(
  parameter int ADDR_W = 19,
  parameter int FCNT_W = 8
);
  logic              enable;
  logic              fmt_565;
  logic              snap_mode;
  logic              snap_req;
  logic              snap_release;
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
`ifdef CAM_CAPTURE_DECIMATE_EN
  logic              decim;
`endif
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              frame_done;
  logic              frozen;
  logic              line_err;
  logic              frame_err;
  logic [FCNT_W-1:0] frame_cnt;

  // master: camera pins plus control; slave: the capture engine
  modport master (
`ifdef CAM_CAPTURE_DECIMATE_EN
    output decim,
`endif
    output enable, fmt_565, snap_mode, snap_req, snap_release,
    output cam_vsync, cam_href, cam_data,
    input  wr_en, wr_addr, wr_data, frame_done, frozen,
    input  line_err, frame_err, frame_cnt
  );

  modport slave (
`ifdef CAM_CAPTURE_DECIMATE_EN
    input  decim,
`endif
    input  enable, fmt_565, snap_mode, snap_req, snap_release,
    input  cam_vsync, cam_href, cam_data,
    output wr_en, wr_addr, wr_data, frame_done, frozen,
    output line_err, frame_err, frame_cnt
  );
endinterface

// File: rtl/cam_frame_capture.sv
// Camera byte stream to 12-bit frame-buffer writes with snapshot mode and geometry checks.
// Optional macro CAM_CAPTURE_DECIMATE_EN: 2:1 decimation in both axes, packed addresses.
module cam_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,  // H_ACTIVE*V_ACTIVE must fit in 2**ADDR_W
  parameter int FCNT_W   = 8
) (
  input  logic               clk,
  input  logic               rstn,
  cam_frame_capture_if.slave cap_if
);
  // Spare bit so a saturated count can never alias the expected geometry.
  localparam int PIX_W  = $clog2(H_ACTIVE + 1) + 1;
  localparam int LINE_W = $clog2(V_ACTIVE + 1) + 1;

  localparam logic [PIX_W-1:0]  PIX_ONE  = PIX_W'(1);
  localparam logic [PIX_W-1:0]  PIX_MAX  = '1;
  localparam logic [PIX_W-1:0]  H_P      = PIX_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);
  localparam logic [LINE_W-1:0] LINE_MAX = '1;
  localparam logic [LINE_W-1:0] V_P      = LINE_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP   = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_FROZEN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                vs_q, vs_prev_q, href_q, href_prev_q;
  logic [7:0]          data_q;
  logic                phase_q, phase_d;
  logic [7:0]          byte0_q, byte0_d;
  logic                fmt_q, fmt_d;
  logic                snap_pend_q, snap_pend_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [11:0]         wr_data_q, wr_data_d;
  logic                frame_done_q;
  logic                line_err_q, line_err_d;
  logic                frame_err_q, frame_err_d;
  logic [FCNT_W-1:0]   fcnt_q;

  logic                vs_rise, vs_fall, href_rise, href_fall;
  logic                in_active, frame_start, frame_end, line_end;
  logic                phase_eff, pix_done, keep_px;
  logic [LINE_W-1:0]   line_after;
  logic [ADDR_W-1:0]   pix_off, base_step;
  logic [11:0]         px_444, px_565;

  assign vs_rise   = vs_q & ~vs_prev_q;
  assign vs_fall   = ~vs_q & vs_prev_q;
  assign href_rise = href_q & ~href_prev_q;
  assign href_fall = ~href_q & href_prev_q;

  assign in_active   = (state_q == ST_ACTIVE) && cap_if.enable;
  assign frame_start = (state_q == ST_WAIT_VS) && cap_if.enable && vs_fall &&
                       (!cap_if.snap_mode || snap_pend_q);
  assign frame_end   = in_active && vs_rise;
  // vsync rising during a line closes that line in the same cycle
  assign line_end    = in_active && (href_fall || (vs_rise && href_q));

  assign phase_eff = href_rise ? 1'b0 : phase_q;
  assign pix_done  = in_active && href_q && phase_eff && !vs_rise;

  assign px_444 = {byte0_q[3:0], data_q};
  assign px_565 = {byte0_q[7:4], byte0_q[2:0], data_q[7], data_q[4:1]};

`ifdef CAM_CAPTURE_DECIMATE_EN
  localparam logic [ADDR_W-1:0] H_HALF = ADDR_W'(H_ACTIVE / 2);
  logic decim_q, decim_d;

  assign decim_d   = frame_start ? cap_if.decim : decim_q;
  assign keep_px   = !decim_q || (!pix_q[0] && !line_q[0]);
  assign pix_off   = decim_q ? ADDR_W'(pix_q >> 1) : ADDR_W'(pix_q);
  // Odd lines are skipped entirely, so only even lines move the base.
  assign base_step = decim_q ? (line_q[0] ? '0 : H_HALF) : H_STEP;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) decim_q <= 1'b0;
    else       decim_q <= decim_d;
  end
`else
  assign keep_px   = 1'b1;
  assign pix_off   = ADDR_W'(pix_q);
  assign base_step = H_STEP;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    state_d = ST_WAIT_VS;
      ST_WAIT_VS: if (frame_start) state_d = ST_ACTIVE;
      ST_ACTIVE:  if (vs_rise) state_d = cap_if.snap_mode ? ST_FROZEN : ST_WAIT_VS;
      ST_FROZEN:  if (cap_if.snap_release) state_d = ST_WAIT_VS;
      default:    state_d = ST_IDLE;
    endcase
    if (!cap_if.enable) state_d = ST_IDLE;
  end

  always_comb begin
    phase_d     = phase_q;
    byte0_d     = byte0_q;
    fmt_d       = fmt_q;
    pix_d       = pix_q;
    line_d      = line_q;
    base_d      = base_q;
    line_err_d  = line_err_q;
    frame_err_d = frame_err_q;
    line_after  = line_q;
    snap_pend_d = cap_if.snap_req || (snap_pend_q && !frame_start);

    if (href_q) begin
      if (!phase_eff) begin
        byte0_d = data_q;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
      end
    end
    if (frame_end) phase_d = 1'b0;

    if (frame_start) begin
      pix_d  = '0;
      line_d = '0;
      base_d = '0;
      fmt_d  = cap_if.fmt_565;
    end else begin
      if (pix_done && pix_q != PIX_MAX) pix_d = pix_q + PIX_ONE;
      if (line_end) begin
        pix_d = '0;
        if (line_q != LINE_MAX) line_after = line_q + LINE_ONE;
        line_d = line_after;
        if (line_q < V_P) base_d = base_q + base_step;
        if (pix_q != H_P) line_err_d = 1'b1;
      end
      if (frame_end && line_after != V_P) frame_err_d = 1'b1;
    end

    if (!cap_if.enable) begin
      line_err_d  = 1'b0;
      frame_err_d = 1'b0;
    end

    wr_en_d   = pix_done && (pix_q < H_P) && (line_q < V_P) && keep_px;
    wr_addr_d = wr_en_d ? base_q + pix_off : wr_addr_q;
    wr_data_d = wr_en_d ? (fmt_q ? px_565 : px_444) : wr_data_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      vs_q         <= 1'b0;
      vs_prev_q    <= 1'b0;
      href_q       <= 1'b0;
      href_prev_q  <= 1'b0;
      data_q       <= '0;
      phase_q      <= 1'b0;
      byte0_q      <= '0;
      fmt_q        <= 1'b0;
      snap_pend_q  <= 1'b0;
      pix_q        <= '0;
      line_q       <= '0;
      base_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      vs_q         <= cap_if.cam_vsync;
      vs_prev_q    <= vs_q;
      href_q       <= cap_if.cam_href;
      href_prev_q  <= href_q;
      data_q       <= cap_if.cam_data;
      phase_q      <= phase_d;
      byte0_q      <= byte0_d;
      fmt_q        <= fmt_d;
      snap_pend_q  <= snap_pend_d;
      pix_q        <= pix_d;
      line_q       <= line_d;
      base_q       <= base_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_end;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
      fcnt_q       <= fcnt_q + FCNT_W'(frame_end);
    end
  end

  assign cap_if.wr_en      = wr_en_q;
  assign cap_if.wr_addr    = wr_addr_q;
  assign cap_if.wr_data    = wr_data_q;
  assign cap_if.frame_done = frame_done_q;
  assign cap_if.frozen     = (state_q == ST_FROZEN);
  assign cap_if.line_err   = line_err_q;
  assign cap_if.frame_err  = frame_err_q;
  assign cap_if.frame_cnt  = fcnt_q;
endmodule

// File: doc/cam_frame_capture.md
Name: cam_frame_capture

Overview:
- Parametrised camera capture engine: turns the camera byte stream (vsync/href/data, already in the `clk` domain) into 12-bit pixel writes for the frame buffer.
- Generalises the earlier fixed 640x480 capture:
  - configurable resolution and address width;
  - selectable RGB444/RGB565 unpacking;
  - single-shot snapshot/freeze mode;
  - per-line and per-frame geometry checking.
- Sits between the camera pins and the frame-buffer write port; the VGA reader is unaffected.

Parameters:
- H_ACTIVE, 640, pixels per line written to memory.
- V_ACTIVE, 480, lines per frame written to memory.
- ADDR_W, 19, frame-buffer address width; must satisfy H_ACTIVE*V_ACTIVE <= 2**ADDR_W.
- FCNT_W, 8, frame counter width.

Ports:
- clk  in  1  capture clock; all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  capture enable; 0 forces IDLE.
- fmt_565  in  1  0 = RGB444 (xRGB), 1 = RGB565; sampled at frame start only.
- snap_mode  in  1  0 = continuous, 1 = single-shot.
- snap_req  in  1  pulse: arm one snapshot (snap_mode=1).
- snap_release  in  1  pulse: leave FROZEN.
- cam_vsync  in  1  camera vsync, active high.
- cam_href  in  1  camera line valid.
- cam_data  in  8  camera byte.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  12  pixel {R,G,B}, 4 bits each.
- frame_done  out  1  one-cycle pulse at the end of each written frame.
- frozen  out  1  high in FROZEN.
- line_err  out  1  sticky: a line's pixel count differed from H_ACTIVE.
- frame_err  out  1  sticky: a frame's line count differed from V_ACTIVE.
- frame_cnt  out  FCNT_W  completed-frame count; wraps.

Behaviour:
- Reset: every output is 0, state is IDLE, and all counters are 0.
- Edge detection: cam_vsync and cam_href are registered once internally; rising and falling edges are taken from the registered copies.
- States:
  - IDLE: entered whenever enable=0, from any state. Goes to WAIT_VS when enable=1.
  - WAIT_VS: goes to ACTIVE on the vsync falling edge. In snap_mode=1 it also needs a latched snap_req (the latch is set by the pulse and cleared on entry to ACTIVE).
  - ACTIVE: goes on the vsync rising edge to:
    - FROZEN if snap_mode=1 (frame_done pulses);
    - WAIT_VS otherwise (frame_done pulses), and the next frame starts at once because vsync will fall again.
  - FROZEN: wr_en is held 0. Goes to WAIT_VS on snap_release. If snap_release and snap_req arrive in the same cycle, the request is latched too.
- Frame start (vsync falling edge, entering ACTIVE): clear the line counter, pixel counter and address base; latch fmt_565.
- Byte phase:
  - resets to 0 on the href rising edge;
  - toggles on every href=1 cycle;
  - the phase-0 byte is held in byte0; on a phase-1 byte the pixel is complete (byte1 = cam_data).
- Pixel packing:
  - RGB444: wr_data = {byte0[3:0], byte1[7:4], byte1[3:0]}.
  - RGB565: wr_data = {byte0[7:4], byte0[2:0], byte1[7], byte1[4:1]}.
- Write timing: wr_en, wr_addr and wr_data are registered and valid the cycle after the phase-1 byte is sampled. Write latency is 2 clk from the phase-1 byte at the pins.
- Write gating: wr_en is issued only when all of the following hold:
  - state is ACTIVE;
  - pixel counter < H_ACTIVE;
  - line counter < V_ACTIVE.
- Excess pixels and lines:
  - excess pixels and lines are dropped (no write);
  - counters keep counting and saturate at all-ones rather than wrapping.
- Address generation:
  - wr_addr = line_base + pix;
  - line_base advances by H_ACTIVE on each href falling edge while line counter < V_ACTIVE;
  - no multiplier is used.
- Line end (href falling edge in ACTIVE):
  - if pixel counter != H_ACTIVE, set line_err;
  - clear the pixel counter and increment the line counter.
- Frame end (vsync rising edge in ACTIVE):
  - if line counter != V_ACTIVE, set frame_err;
  - frame_cnt increments;
  - a half pixel (phase 1 pending) is discarded.
- A vsync rising edge while href=1 is treated as line end and then frame end in the same cycle.
- Error clearing: line_err and frame_err clear only on reset or on enable going 0.
- Deasserting enable mid-frame stops writes in the next cycle; the partial frame gives no frame_done.

Optional Feature:
- Macro: CAM_CAPTURE_DECIMATE_EN.
- Defined:
  - adds input decim (1 bit), latched at frame start;
  - when decim=1, only even pixels of even lines are written;
  - the geometry checks still use H_ACTIVE and V_ACTIVE;
  - written image is (H_ACTIVE/2)x(V_ACTIVE/2);
  - line_base advances by H_ACTIVE/2 on even lines only;
  - addresses are packed contiguously from 0.
- Undefined: no decim port; behaviour exactly as above.

Test Plan:
- H_ACTIVE=8, V_ACTIVE=4, RGB444, continuous.
  - Stimulus: one frame of 4 lines x 16 bytes, byte pair (0x0A,0x5C).
  - Required: 32 writes, addresses 0..31, wr_data=0xA5C, frame_done pulses once, frame_cnt=1, no errors.
- RGB565.
  - Stimulus: pair (0xF8,0x1F).
  - Required: wr_data=0xF0F. Pair (0x07,0xE0) gives 0x0F0.
- Snap_mode=1.
  - Stimulus: snap_req, then 3 frames.
  - Required: exactly 32 writes, then frozen=1 and no further wr_en. snap_release plus snap_req gives one more frame of 32 writes.
- Geometry error.
  - Stimulus: line of 10 pixels, then a frame of 5 lines.
  - Required: only addresses below 32 are written, line_err=1 and frame_err=1; enable low clears both.
- Reset mid-frame.
  - Stimulus: rstn low at pixel 3 of line 1.
  - Required: all outputs are 0 immediately; after release no writes occur until the next vsync falling edge, and addresses restart at 0.
- With CAM_CAPTURE_DECIMATE_EN, decim=1 and an 8x4 frame.
  - Required: 8 writes, addresses 0..7, taken from pixels 0,2,4,6 of lines 0 and 2.
